// File: rtl/vcpu_mem_dma.sv
// vcpu_mem_dma -- second bus master for the vcpu_mem port.
//
// Runs block FILL, FILL_INC, COPY and CHECK operations on memory while the CPU
// is parked off the port (an external mux hands the port over while busy=1).
// Memory contract: write on rising clk when memWE=1, memQ is combinational
// from memAddress.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           command strobe, only honoured in IDLE
//   mode            0=FILL 1=COPY 2=CHECK 3=FILL_INC
//   srcAddr         COPY source base
//   dstAddr         FILL/COPY destination, CHECK base
//   length          byte count (0 = no memory access)
//   pattern         fill / compare byte, FILL_INC base value
//   busy            operation owns the memory port
//   done            one-cycle completion (or CHECK abort) pulse
//   error, errAddr  sticky CHECK mismatch flag and first mismatching address
//   memWE, memAddress, memData, memQ   memory port
module vcpu_mem_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] errAddr,
  output logic                  memWE,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memData,
  input  logic [DATA_WIDTH-1:0] memQ
);

  localparam logic [1:0] MODE_FILL    = 2'd0;
  localparam logic [1:0] MODE_COPY    = 2'd1;
  localparam logic [1:0] MODE_CHECK   = 2'd2;
  localparam logic [1:0] MODE_FILLINC = 2'd3;

  // EMPTY is the single busy cycle of a zero-length command; it touches no memory.
  typedef enum logic [2:0] {
    IDLE, FILL, COPY_RD, COPY_WR, CHECK, EMPTY, DONE
  } state_t;

  state_t                state;
  logic [1:0]            modeR;
  logic [ADDR_WIDTH-1:0] srcR;
  logic [ADDR_WIDTH-1:0] dstR;
  logic [ADDR_WIDTH-1:0] lenR;
  logic [DATA_WIDTH-1:0] patR;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] buf_q;

  logic [ADDR_WIDTH-1:0] idxNext;
  logic                  lastByte;

  assign idxNext  = idx + ADDR_WIDTH'(1);
  assign lastByte = (idx == lenR - ADDR_WIDTH'(1));

  // Outputs are registered: every transition loads the port values for the
  // cycle being entered, so memAddress/memData/memWE always describe the
  // current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      errAddr    <= '0;
      memWE      <= 1'b0;
      memAddress <= '0;
      memData    <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          memWE      <= 1'b0;
          memAddress <= '0;
          memData    <= '0;
          if (start) begin
            modeR <= mode;
            srcR  <= srcAddr;
            dstR  <= dstAddr;
            lenR  <= length;
            patR  <= pattern;
            idx   <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            if (length == '0) begin
              state <= EMPTY;
            end else begin
              case (mode)
                MODE_COPY: begin
                  state      <= COPY_RD;
                  memAddress <= srcAddr;
                end
                MODE_CHECK: begin
                  state      <= CHECK;
                  memAddress <= dstAddr;
                end
                default: begin
                  // FILL and FILL_INC share the state; byte 0 is pattern+0 in both.
                  state      <= FILL;
                  memWE      <= 1'b1;
                  memAddress <= dstAddr;
                  memData    <= pattern;
                end
              endcase
            end
          end
        end

        FILL: begin
          if (lastByte) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            memWE      <= 1'b0;
            memAddress <= '0;
            memData    <= '0;
          end else begin
            idx        <= idxNext;
            memAddress <= dstR + idxNext;
            memData    <= (modeR == MODE_FILLINC) ? patR + DATA_WIDTH'(idxNext) : patR;
          end
        end

        COPY_RD: begin
          buf_q      <= memQ;
          memData    <= memQ;
          memWE      <= 1'b1;
          memAddress <= dstR + idx;
          state      <= COPY_WR;
        end

        COPY_WR: begin
          memWE <= 1'b0;
          if (lastByte) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            memAddress <= '0;
            memData    <= '0;
          end else begin
            idx        <= idxNext;
            memAddress <= srcR + idxNext;
            memData    <= buf_q;
            state      <= COPY_RD;
          end
        end

        CHECK: begin
          // First mismatch aborts: later bytes are never read.
          if (memQ != patR || lastByte) begin
            if (memQ != patR) begin
              error   <= 1'b1;
              errAddr <= memAddress;
            end
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            memAddress <= '0;
          end else begin
            idx        <= idxNext;
            memAddress <= dstR + idxNext;
          end
        end

        EMPTY: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        DONE: begin
          // start is deliberately not looked at here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          memWE <= 1'b0;
        end
      endcase
    end
  end

endmodule
